cache_arbiter: RTL and testbench

Shares the single physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core. A registered three-state FSM grants one cache at a time and steers that cache's line request to physical memory. It returns the response only to the granted cache. On simultaneous demand it alternates between the two caches so neither pipeline stage starves.

---
 rtl/lc3b_types.sv | 17 +
 rtl/cache_arbiter.sv | 124 ++++++++++++
 tb/tb_cache_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared type definitions for the LC-3b pipelined core.
package lc3b_types;

    typedef logic [127:0] lc3b_c_line;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares the physical-memory port between the icache and the dcache.
// One cache is granted at a time, and that cache's line request is steered to memory.
// Simultaneous demand alternates between the caches, using the last grant.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ARB_IDLE     | no grant; samples fresh requests; memory port quiet
// ARB_SERVE_I  | icache owns memory; line read at i_address until pmem_resp
// ARB_SERVE_D  | dcache owns memory; writeback or fill at d_address until pmem_resp
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    arb_req_t   r_last_grant;
    arb_req_t   w_next_grant;
    logic       w_d_req;

    assign w_d_req = d_read | d_write;

    // State and last-grant registers; reset leaves last_grant at I so D wins the first conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= REQ_I;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_grant;
        end
    end

    // Next-state: grant from IDLE, release on pmem_resp; pmem_resp in IDLE is ignored
    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_last_grant;
        case (r_state)
            ARB_IDLE: begin
                if (i_read && w_d_req) begin
                    if (r_last_grant == REQ_I) begin
                        w_next_state = ARB_SERVE_D;
                        w_next_grant = REQ_D;
                    end else begin
                        w_next_state = ARB_SERVE_I;
                        w_next_grant = REQ_I;
                    end
                end else if (i_read) begin
                    w_next_state = ARB_SERVE_I;
                    w_next_grant = REQ_I;
                end else if (w_d_req) begin
                    w_next_state = ARB_SERVE_D;
                    w_next_grant = REQ_D;
                end
            end
            ARB_SERVE_I: begin
                if (pmem_resp) w_next_state = ARB_IDLE;
            end
            ARB_SERVE_D: begin
                if (pmem_resp) w_next_state = ARB_IDLE;
            end
            default: begin
                w_next_state = ARB_IDLE;
            end
        endcase
    end

    // Memory-port outputs decoded from the registered state; a dcache read+write counts as a write
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            ARB_SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
            end
            ARB_SERVE_D: begin
                pmem_address = d_address;
                if (d_write) begin
                    pmem_write = 1'b1;
                    pmem_wdata = d_wdata;
                end else begin
                    pmem_read  = 1'b1;
                end
            end
            default: begin
                pmem_read    = 1'b0;
            end
        endcase
    end

    // Response gating: only the granted cache sees pmem_resp; the line data is shared
    assign i_resp  = pmem_resp && (r_state == ARB_SERVE_I);
    assign d_resp  = pmem_resp && (r_state == ARB_SERVE_D);
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: a directed vector table plus hand-written
// sequences for round-robin alternation and reset during a transaction.
module tb_cache_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    typedef struct {
        logic          rst;
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dw;
        logic [AW-1:0] da;
        logic [LW-1:0] wd;
        logic          pr;
        logic [LW-1:0] rd;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_a;
        logic [LW-1:0] e_wd;
        logic          e_ir;
        logic          e_dr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [LW-1:0] W = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [LW-1:0] Z = '0;

    function automatic vec_t mk(input logic r, input logic ir, input logic [AW-1:0] ia,
                                input logic dr, input logic dw, input logic [AW-1:0] da,
                                input logic [LW-1:0] wd, input logic pr, input logic [LW-1:0] rd,
                                input logic e_rd, input logic e_wr, input logic [AW-1:0] e_a,
                                input logic [LW-1:0] e_wd, input logic e_ir, input logic e_dr);
        vec_t v;
        v.rst = r;   v.ir = ir;  v.ia = ia;  v.dr = dr;  v.dw = dw;  v.da = da;
        v.wd = wd;   v.pr = pr;  v.rd = rd;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_a = e_a; v.e_wd = e_wd;
        v.e_ir = e_ir; v.e_dr = e_dr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dw, input logic [AW-1:0] da,
                         input logic [LW-1:0] wd, input logic pr);
        rst = r; i_read = ir; i_address = ia; d_read = dr; d_write = dw;
        d_address = da; d_wdata = wd; pmem_resp = pr;
    endtask

    // advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, Z, 0);
        pmem_rdata = Z;
        next_cycle();
        next_cycle();

        // rst  ir ia       dr dw da       wd pr rd       e_rd e_wr e_a      e_wd ir dr
        vecs.push_back(mk(1, 0, 0,       0, 0, 0,       Z, 0, 128'h11, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 1, 16'h1230,0, 0, 0,       Z, 0, 128'h12, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 1, 16'h1230,0, 0, 0,       Z, 0, 128'h13, 1, 0, 16'h1230,Z, 0, 0));
        vecs.push_back(mk(0, 1, 16'h1230,0, 0, 0,       Z, 0, 128'h14, 1, 0, 16'h1230,Z, 0, 0));
        vecs.push_back(mk(0, 1, 16'h1230,0, 0, 0,       Z, 1, 128'h15, 1, 0, 16'h1230,Z, 1, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       Z, 0, 128'h16, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 1, 16'h0040,W, 0, 128'h17, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 1, 16'h0040,W, 0, 128'h18, 0, 1, 16'h0040,W, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 1, 16'h0040,W, 1, 128'h19, 0, 1, 16'h0040,W, 0, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       Z, 0, 128'h1A, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       Z, 1, 128'h1B, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       Z, 0, 128'h1C, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 0, 16'h0080,Z, 0, 128'h1D, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 0, 16'h0080,Z, 1, 128'h1E, 1, 0, 16'h0080,Z, 0, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       Z, 0, 128'h1F, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0100,1, 0, 16'h0200,Z, 0, 128'h20, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 1, 16'h0100,1, 0, 16'h0200,Z, 1, 128'h21, 1, 0, 16'h0100,Z, 1, 0));
        vecs.push_back(mk(0, 0, 0,       1, 0, 16'h0200,Z, 0, 128'h22, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 0, 16'h0200,Z, 1, 128'h23, 1, 0, 16'h0200,Z, 0, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       Z, 0, 128'h24, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 1, 16'h0300,W, 0, 128'h25, 0, 0, 0,       Z, 0, 0));
        vecs.push_back(mk(0, 0, 0,       1, 1, 16'h0300,W, 1, 128'h26, 0, 1, 16'h0300,W, 0, 1));
        vecs.push_back(mk(0, 0, 0,       0, 0, 0,       Z, 0, 128'h27, 0, 0, 0,       Z, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw,
                  vecs[i].da, vecs[i].wd, vecs[i].pr);
            pmem_rdata = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d.pmem_read", i),    LW'(pmem_read),    LW'(vecs[i].e_rd));
            chk($sformatf("v%0d.pmem_write", i),   LW'(pmem_write),   LW'(vecs[i].e_wr));
            chk($sformatf("v%0d.pmem_address", i), LW'(pmem_address), LW'(vecs[i].e_a));
            chk($sformatf("v%0d.pmem_wdata", i),   pmem_wdata,        vecs[i].e_wd);
            chk($sformatf("v%0d.i_resp", i),       LW'(i_resp),       LW'(vecs[i].e_ir));
            chk($sformatf("v%0d.d_resp", i),       LW'(d_resp),       LW'(vecs[i].e_dr));
            chk($sformatf("v%0d.i_rdata", i),      i_rdata,           vecs[i].rd);
            chk($sformatf("v%0d.d_rdata", i),      d_rdata,           vecs[i].rd);
            next_cycle();
        end

        // Both caches request continuously after reset; single-cycle memory.
        begin
            byte grants[$];
            int  gcyc[$];
            drive(1, 0, 0, 0, 0, 0, Z, 0);
            next_cycle();
            drive(0, 1, 16'h1000, 1, 0, 16'h2000, Z, 0);
            for (int c = 0; c < 40 && grants.size() < 4; c++) begin
                pmem_resp = pmem_read | pmem_write;
                @(negedge clk);
                if (pmem_read && pmem_address == 16'h1000) begin
                    grants.push_back("I");
                    gcyc.push_back(c);
                    chk($sformatf("rr%0d.i_resp", grants.size()), LW'(i_resp), LW'(1));
                    chk($sformatf("rr%0d.d_resp", grants.size()), LW'(d_resp), LW'(0));
                end else if (pmem_read && pmem_address == 16'h2000) begin
                    grants.push_back("D");
                    gcyc.push_back(c);
                    chk($sformatf("rr%0d.d_resp", grants.size()), LW'(d_resp), LW'(1));
                    chk($sformatf("rr%0d.i_resp", grants.size()), LW'(i_resp), LW'(0));
                end
                next_cycle();
            end
            chk("rr.grant_count", LW'(grants.size()), LW'(4));
            if (grants.size() == 4) begin
                chk("rr.first_latency", LW'(gcyc[0]), LW'(1));
                chk("rr.order0", LW'(grants[0]), LW'(8'("D")));
                chk("rr.order1", LW'(grants[1]), LW'(8'("I")));
                chk("rr.order2", LW'(grants[2]), LW'(8'("D")));
                chk("rr.order3", LW'(grants[3]), LW'(8'("I")));
                for (int k = 1; k < 4; k++)
                    chk($sformatf("rr.gap%0d", k), LW'(gcyc[k] - gcyc[k-1]), LW'(2));
            end
            drive(0, 0, 0, 0, 0, 0, Z, 0);
            next_cycle();
            next_cycle();
        end

        // D-only writeback to make last_grant D, then reset in its second SERVE_D cycle.
        drive(0, 0, 0, 1, 0, 16'h0500, Z, 0);
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("pre.d_resp", LW'(d_resp), LW'(1));
        next_cycle();
        drive(0, 0, 0, 0, 1, 16'h0040, W, 0);
        next_cycle();
        @(negedge clk);
        chk("rst.serve_d_cycle1", LW'(pmem_write), LW'(1));
        next_cycle();
        drive(1, 0, 0, 0, 1, 16'h0040, W, 0);
        @(negedge clk);
        chk("rst.serve_d_cycle2", LW'(pmem_write), LW'(1));
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, Z, 1);
        @(negedge clk);
        chk("rst.write_dropped", LW'(pmem_write), LW'(0));
        chk("rst.read_dropped", LW'(pmem_read), LW'(0));
        chk("rst.late_resp_d", LW'(d_resp), LW'(0));
        chk("rst.late_resp_i", LW'(i_resp), LW'(0));
        next_cycle();
        drive(0, 1, 16'h1000, 1, 0, 16'h2000, Z, 0);
        @(negedge clk);
        chk("rst.idle_after", LW'(pmem_read), LW'(0));
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("rst.grant_d_read", LW'(pmem_read), LW'(1));
        chk("rst.grant_d_addr", LW'(pmem_address), LW'(16'h2000));
        chk("rst.grant_d_resp", LW'(d_resp), LW'(1));
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, Z, 0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
